// File: rtl/gat_sched_pkg.sv
// Shared types and constants for the GAT layer scheduler.
// Byte addressing is word index shifted by BYTE_SHIFT.
package gat_sched_pkg;

  localparam int BYTE_SHIFT           = 2;
  localparam int DEF_TOP_WIDTH        = 32;
  localparam int DEF_H_DATA_ADDR_W    = 18;
  localparam int DEF_NODE_INFO_ADDR_W = 14;
  localparam int DEF_WEIGHT_ADDR_W    = 15;
  localparam int DEF_NEW_FEAT_ADDR_W  = 16;
  localparam int DEF_NUM_LAYERS       = 2;

  typedef enum logic [2:0] {
    IDLE, LD_H, LD_NI, LD_W, RUN, DRAIN, NEXT, DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gat_sched_out_fifo.sv
// Two-entry output FIFO (data + last); push lands next cycle, pop is combinational from head.
// Backpressure: caller guarantees no push into a full FIFO unless popping the same cycle.
module gat_sched_out_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         vld,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign vld     = (cnt != 2'd0);
  assign occ     = cnt;
  assign pop_dat = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Sequences GAT layers: DMA load of three BRAMs, wait for gat_ready edge, drain feature BRAM.
// Loads accept one beat/cycle; drain keeps at most two words buffered or in flight.
module gat_layer_scheduler
  import gat_sched_pkg::*;
#(
  parameter int TOP_WIDTH          = DEF_TOP_WIDTH,
  parameter int H_DATA_ADDR_W      = DEF_H_DATA_ADDR_W,
  parameter int NODE_INFO_ADDR_W   = DEF_NODE_INFO_ADDR_W,
  parameter int WEIGHT_ADDR_W      = DEF_WEIGHT_ADDR_W,
  parameter int NEW_FEATURE_ADDR_W = DEF_NEW_FEAT_ADDR_W,
  parameter int NUM_LAYERS         = DEF_NUM_LAYERS
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [NUM_LAYERS*(H_DATA_ADDR_W+1)-1:0]    cfg_h_len,
  input  logic [NUM_LAYERS*(NODE_INFO_ADDR_W+1)-1:0] cfg_ni_len,
  input  logic [NUM_LAYERS*(WEIGHT_ADDR_W+1)-1:0]    cfg_wgt_len,
  input  logic [NUM_LAYERS*(NEW_FEATURE_ADDR_W+1)-1:0] cfg_feat_len,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [TOP_WIDTH-1:0]                       s_data,
  output logic [TOP_WIDTH-1:0]                       h_data_bram_din,
  output logic                                       h_data_bram_ena,
  output logic                                       h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]                   h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]                       h_node_info_bram_din,
  output logic                                       h_node_info_bram_ena,
  output logic                                       h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0]                h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]                       wgt_bram_din,
  output logic                                       wgt_bram_ena,
  output logic                                       wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]                   wgt_bram_addra,
  output logic                                       h_data_bram_load_done,
  output logic                                       h_node_info_bram_load_done,
  output logic                                       wgt_bram_load_done,
  output logic                                       gat_layer,
  input  logic                                       gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0]              feat_bram_addrb,
  input  logic [TOP_WIDTH-1:0]                       feat_bram_dout,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic [TOP_WIDTH-1:0]                       m_data,
  output logic                                       m_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int HL    = H_DATA_ADDR_W + 1;
  localparam int NL    = NODE_INFO_ADDR_W + 1;
  localparam int WL    = WEIGHT_ADDR_W + 1;
  localparam int FL    = NEW_FEATURE_ADDR_W + 1;
  localparam int CNT_W = max_int(max_int(HL, NL), WL);

  state_t state, state_nxt;

  logic [NUM_LAYERS*HL-1:0] h_len_q;
  logic [NUM_LAYERS*NL-1:0] ni_len_q;
  logic [NUM_LAYERS*WL-1:0] wgt_len_q;
  logic [NUM_LAYERS*FL-1:0] feat_len_q;

  logic             layer;
  int               lyr;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] phase_len;
  logic [FL-1:0]    rd_cnt;
  logic [FL-1:0]    feat_len;
  logic             rd_pend;
  logic             rd_last_pend;
  logic             gr_prev;
  logic             in_load;
  logic             beat;
  logic             phase_end;
  logic             rd_issue;
  logic             drain_end;
  logic [1:0]       fifo_occ;

  assign lyr      = int'(layer);
  assign feat_len = feat_len_q[lyr*FL +: FL];
  assign in_load  = (state == LD_H) || (state == LD_NI) || (state == LD_W);

  always_comb begin
    phase_len = '0;
    case (state)
      LD_H:    phase_len = CNT_W'(h_len_q[lyr*HL +: HL]);
      LD_NI:   phase_len = CNT_W'(ni_len_q[lyr*NL +: NL]);
      LD_W:    phase_len = CNT_W'(wgt_len_q[lyr*WL +: WL]);
      default: phase_len = '0;
    endcase
  end

  // Zero-length phases never raise s_ready, so no stray beat can be consumed.
  assign s_ready   = in_load && (phase_len != '0);
  assign beat      = s_valid && s_ready;
  assign phase_end = in_load &&
                     ((phase_len == '0) || (beat && ((word_cnt + CNT_W'(1)) == phase_len)));

  assign h_data_bram_ena        = beat && (state == LD_H);
  assign h_data_bram_wea        = h_data_bram_ena;
  assign h_data_bram_din        = h_data_bram_ena ? s_data : '0;
  assign h_data_bram_addra      = h_data_bram_ena ? ((H_DATA_ADDR_W+2)'(word_cnt) << BYTE_SHIFT) : '0;
  assign h_node_info_bram_ena   = beat && (state == LD_NI);
  assign h_node_info_bram_wea   = h_node_info_bram_ena;
  assign h_node_info_bram_din   = h_node_info_bram_ena ? s_data : '0;
  assign h_node_info_bram_addra = h_node_info_bram_ena ?
                                  ((NODE_INFO_ADDR_W+2)'(word_cnt) << BYTE_SHIFT) : '0;
  assign wgt_bram_ena           = beat && (state == LD_W);
  assign wgt_bram_wea           = wgt_bram_ena;
  assign wgt_bram_din           = wgt_bram_ena ? s_data : '0;
  assign wgt_bram_addra         = wgt_bram_ena ? ((WEIGHT_ADDR_W+2)'(word_cnt) << BYTE_SHIFT) : '0;

  // Reads are credited against FIFO occupancy plus the one read still in flight.
  assign rd_issue        = (state == DRAIN) && (rd_cnt < feat_len) &&
                           ((fifo_occ + {1'b0, rd_pend}) < 2'd2);
  assign feat_bram_addrb = rd_issue ? ((NEW_FEATURE_ADDR_W+2)'(rd_cnt) << BYTE_SHIFT) : '0;
  assign drain_end       = (state == DRAIN) &&
                           ((feat_len == '0) || (m_valid && m_ready && m_last));

  gat_sched_out_fifo #(.W(TOP_WIDTH + 1)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend),
    .push_dat ({rd_last_pend, feat_bram_dout}),
    .pop      (m_ready),
    .pop_dat  ({m_last, m_data}),
    .vld      (m_valid),
    .occ      (fifo_occ)
  );

  assign gat_layer = layer;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LD_H;
      LD_H:    if (phase_end) state_nxt = LD_NI;
      LD_NI:   if (phase_end) state_nxt = LD_W;
      LD_W:    if (phase_end) state_nxt = RUN;
      RUN:     if (gat_ready && !gr_prev) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = (lyr < NUM_LAYERS - 1) ? NEXT : DONE;
      NEXT:    state_nxt = LD_H;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_len_q                    <= '0;
      ni_len_q                   <= '0;
      wgt_len_q                  <= '0;
      feat_len_q                 <= '0;
      layer                      <= 1'b0;
      word_cnt                   <= '0;
      rd_cnt                     <= '0;
      rd_pend                    <= 1'b0;
      rd_last_pend               <= 1'b0;
      gr_prev                    <= 1'b1;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
    end else begin
      gr_prev      <= gat_ready;
      rd_pend      <= rd_issue;
      rd_last_pend <= rd_issue && ((rd_cnt + FL'(1)) == feat_len);
      if ((state == IDLE) && start) begin
        h_len_q    <= cfg_h_len;
        ni_len_q   <= cfg_ni_len;
        wgt_len_q  <= cfg_wgt_len;
        feat_len_q <= cfg_feat_len;
        layer      <= 1'b0;
      end
      if (phase_end)   word_cnt <= '0;
      else if (beat)   word_cnt <= word_cnt + CNT_W'(1);
      if (phase_end && (state == LD_H))  h_data_bram_load_done      <= 1'b1;
      if (phase_end && (state == LD_NI)) h_node_info_bram_load_done <= 1'b1;
      if (phase_end && (state == LD_W))  wgt_bram_load_done         <= 1'b1;
      if ((state == NEXT) || (state == IDLE)) begin
        h_data_bram_load_done      <= 1'b0;
        h_node_info_bram_load_done <= 1'b0;
        wgt_bram_load_done         <= 1'b0;
      end
      if (state == NEXT) layer <= layer + 1'b1;
      if (state == DONE) layer <= 1'b0;
      if (drain_end)     rd_cnt <= '0;
      else if (rd_issue) rd_cnt <= rd_cnt + FL'(1);
    end
  end

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Directed bench for gat_layer_scheduler: DMA source, feature BRAM model, gat_ready responder.
module tb_gat_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [37:0] cfg_h_len = '0;
  logic [29:0] cfg_ni_len = '0;
  logic [31:0] cfg_wgt_len = '0;
  logic [33:0] cfg_feat_len = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] h_data_bram_din, h_node_info_bram_din, wgt_bram_din;
  logic        h_data_bram_ena, h_data_bram_wea, h_node_info_bram_ena, h_node_info_bram_wea;
  logic        wgt_bram_ena, wgt_bram_wea;
  logic [19:0] h_data_bram_addra;
  logic [15:0] h_node_info_bram_addra;
  logic [16:0] wgt_bram_addra;
  logic        h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;
  logic        gat_layer;
  logic        gat_ready = 1'b0;
  logic [17:0] feat_bram_addrb;
  logic [31:0] feat_bram_dout = '0;
  logic        m_valid, m_last, busy, done;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;

  gat_layer_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h_len(cfg_h_len), .cfg_ni_len(cfg_ni_len),
    .cfg_wgt_len(cfg_wgt_len), .cfg_feat_len(cfg_feat_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
    .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
    .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
    .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
    .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
    .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
    .h_data_bram_load_done(h_data_bram_load_done),
    .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .wgt_bram_load_done(wgt_bram_load_done),
    .gat_layer(gat_layer), .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] SRC_BASE  = 32'hA000_0000;
  localparam logic [31:0] FEAT_BASE = 32'hC0DE_0000;

  int n_chk = 0;
  int n_err = 0;

  // stimulus controls (written by the main initial only)
  logic clr_req = 1'b0;
  logic tog_mode = 1'b0;
  logic mr_mode = 1'b0;
  logic gr_auto = 1'b1;
  logic gr_man = 1'b0;
  logic [5:0] mr_pat = 6'b011001;  // bit i = m_ready at cycle i mod 6: 1,0,0,1,1,0

  // monitor state (written by the negedge monitor only)
  int          cyc = 0;
  int          src_idx = 0;
  logic [63:0] h_q[$], ni_q[$], w_q[$], m_q[$];
  int          done_cnt = 0;
  int          h_done_cyc = 0, h_last_cyc = 0;
  logic        h_done_seen = 1'b0;
  logic [2:0]  ld_at_l1 = 3'b111;
  logic        layer_prev = 1'b0;
  int          h_wr_l1 = 0, ni_wr_l1 = 0, w_wr_l1 = 0;
  int          m_viol = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_md = '0;
  logic [17:0] feat_addr_smp = '0;

  // driver state (written by the posedge driver only)
  logic        tog = 1'b0;
  int          gr_dly = 0;
  logic [3:0]  gr_snap_q[$];

  always @(negedge clk) begin
    if (clr_req) begin
      cyc = 0; src_idx = 0; done_cnt = 0;
      h_q.delete(); ni_q.delete(); w_q.delete(); m_q.delete();
      h_done_cyc = 0; h_last_cyc = 0; h_done_seen = 1'b0;
      ld_at_l1 = 3'b111; layer_prev = 1'b0;
      h_wr_l1 = 0; ni_wr_l1 = 0; w_wr_l1 = 0;
      m_viol = 0; prev_stall = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (s_valid && s_ready) src_idx = src_idx + 1;
      if (h_data_bram_ena && h_data_bram_wea) begin
        h_q.push_back({32'(h_data_bram_addra), h_data_bram_din});
        h_last_cyc = cyc;
        if (gat_layer) h_wr_l1 = h_wr_l1 + 1;
      end
      if (h_node_info_bram_ena && h_node_info_bram_wea) begin
        ni_q.push_back({32'(h_node_info_bram_addra), h_node_info_bram_din});
        if (gat_layer) ni_wr_l1 = ni_wr_l1 + 1;
      end
      if (wgt_bram_ena && wgt_bram_wea) begin
        w_q.push_back({32'(wgt_bram_addra), wgt_bram_din});
        if (gat_layer) w_wr_l1 = w_wr_l1 + 1;
      end
      if (h_data_bram_load_done && !h_done_seen) begin
        h_done_seen = 1'b1;
        h_done_cyc = cyc;
      end
      if (gat_layer && !layer_prev)
        ld_at_l1 = {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done};
      layer_prev = gat_layer;
      if (prev_stall && (!m_valid || ({m_last, m_data} != prev_md))) m_viol = m_viol + 1;
      prev_stall = m_valid && !m_ready;
      prev_md = {m_last, m_data};
      if (m_valid && m_ready) m_q.push_back(64'({m_last, m_data}));
      if (done) done_cnt = done_cnt + 1;
    end
    feat_addr_smp = feat_bram_addrb;
  end

  int src_n = 1000;
  always @(posedge clk) begin
    #1;
    if (clr_req) gr_snap_q.delete();
    tog = ~tog;
    s_valid = !rst && (src_idx < src_n) && (!tog_mode || tog);
    s_data = SRC_BASE + 32'(src_idx);
    m_ready = mr_mode ? mr_pat[cyc % 6] : 1'b1;
    feat_bram_dout = FEAT_BASE + 32'(feat_addr_smp >> 2);
    if (!gr_auto) begin
      gat_ready = gr_man;
    end else if (!(h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done)) begin
      gat_ready = 1'b0;
      gr_dly = 0;
    end else if (!gat_ready) begin
      if (gr_dly == 3) begin
        gat_ready = 1'b1;
        gr_snap_q.push_back({gat_layer, h_data_bram_load_done,
                             h_node_info_bram_load_done, wgt_bram_load_done});
      end else begin
        gr_dly = gr_dly + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs_vec();
    return {busy, done, s_ready, h_data_bram_ena, h_data_bram_wea,
            h_node_info_bram_ena, h_node_info_bram_wea, wgt_bram_ena, wgt_bram_wea,
            h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done,
            gat_layer, m_valid, m_last, |feat_bram_addrb};
  endfunction

  function automatic logic outs_bus_or();
    return |{h_data_bram_din, h_data_bram_addra, h_node_info_bram_din, h_node_info_bram_addra,
             wgt_bram_din, wgt_bram_addra, m_data};
  endfunction

  task automatic set_cfg(input int h0, ni0, w0, f0, h1, ni1, w1, f1);
    cfg_h_len    = {19'(h1), 19'(h0)};
    cfg_ni_len   = {15'(ni1), 15'(ni0)};
    cfg_wgt_len  = {16'(w1), 16'(w0)};
    cfg_feat_len = {17'(f1), 17'(f0)};
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    clr_req = 1'b0;
  endtask

  // start pulse; cfg is scrambled afterwards since the DUT must have latched it
  task automatic start_run();
    @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    cfg_h_len = '1; cfg_ni_len = '1; cfg_wgt_len = '1; cfg_feat_len = '1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 64'(done_cnt != 0), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_outs", 64'(outs_vec()), 64'(0));
    check("rst_bus", 64'(outs_bus_or()), 64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", 64'(outs_vec()), 64'(0));

    // 1) single effective layer: h=3 ni=2 w=2 feat=4
    set_cfg(3, 2, 2, 4, 0, 0, 0, 0);
    clear_mon();
    start_run();
    wait_done("t1");
    check("t1_h_cnt", 64'(h_q.size()), 64'(3));
    foreach (h_q[i]) check("t1_h", h_q[i], {32'(4 * i), SRC_BASE + 32'(i)});
    check("t1_ni_cnt", 64'(ni_q.size()), 64'(2));
    foreach (ni_q[i]) check("t1_ni", ni_q[i], {32'(4 * i), SRC_BASE + 32'(3 + i)});
    check("t1_w_cnt", 64'(w_q.size()), 64'(2));
    foreach (w_q[i]) check("t1_w", w_q[i], {32'(4 * i), SRC_BASE + 32'(5 + i)});
    check("t1_snap0", 64'(gr_snap_q.size() > 0 ? gr_snap_q[0] : 4'hF), 64'(4'b0111));
    check("t1_m_cnt", 64'(m_q.size()), 64'(4));
    foreach (m_q[i]) check("t1_m", m_q[i], 64'({i == 3, FEAT_BASE + 32'(i)}));
    check("t1_done_cnt", 64'(done_cnt), 64'(1));
    check("t1_idle", 64'(outs_vec()), 64'(0));

    // 2) s_valid toggling, h=5
    set_cfg(5, 0, 0, 0, 0, 0, 0, 0);
    tog_mode = 1'b1;
    clear_mon();
    start_run();
    wait_done("t2");
    tog_mode = 1'b0;
    check("t2_h_cnt", 64'(h_q.size()), 64'(5));
    foreach (h_q[i]) check("t2_h", h_q[i], {32'(4 * i), SRC_BASE + 32'(i)});
    check("t2_done_lag", 64'(h_done_cyc - h_last_cyc), 64'(1));
    check("t2_ni_w_cnt", 64'(ni_q.size() + w_q.size()), 64'(0));

    // 3) gat_ready already high on RUN entry
    set_cfg(1, 0, 0, 1, 0, 0, 0, 0);
    gr_auto = 1'b0;
    gr_man = 1'b1;
    clear_mon();
    start_run();
    begin
      int k = 0;
      while (!(h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done)
             && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("t3_loaded", 64'(h_data_bram_load_done && wgt_bram_load_done), 64'(1));
    repeat (10) @(negedge clk);
    check("t3_busy", 64'(busy), 64'(1));
    check("t3_no_drain", 64'(m_q.size()), 64'(0));
    check("t3_hold_ld", 64'({h_data_bram_load_done, h_node_info_bram_load_done,
                            wgt_bram_load_done}), 64'(3'b111));
    gr_man = 1'b0;
    repeat (3) @(posedge clk);
    gr_man = 1'b1;
    repeat (3) @(posedge clk);
    gr_auto = 1'b1;
    wait_done("t3");
    check("t3_m_cnt", 64'(m_q.size()), 64'(1));
    check("t3_m0", m_q.size() > 0 ? m_q[0] : '1, 64'({1'b1, FEAT_BASE}));

    // 4) drain feat=6 under m_ready 1,0,0,1,1,0
    set_cfg(1, 1, 1, 6, 0, 0, 0, 0);
    mr_mode = 1'b1;
    clear_mon();
    start_run();
    wait_done("t4");
    mr_mode = 1'b0;
    check("t4_m_cnt", 64'(m_q.size()), 64'(6));
    foreach (m_q[i]) check("t4_m", m_q[i], 64'({i == 5, FEAT_BASE + 32'(i)}));
    check("t4_m_hold", 64'(m_viol), 64'(0));

    // 5) two layers, layer 1 with h=0 ni=0
    set_cfg(2, 1, 1, 2, 0, 0, 2, 3);
    clear_mon();
    start_run();
    wait_done("t5");
    check("t5_ld_cleared", 64'(ld_at_l1), 64'(0));
    check("t5_l1_h_ni_wr", 64'(h_wr_l1 + ni_wr_l1), 64'(0));
    check("t5_l1_w_wr", 64'(w_wr_l1), 64'(2));
    check("t5_h_cnt", 64'(h_q.size()), 64'(2));
    check("t5_w_cnt", 64'(w_q.size()), 64'(3));
    if (w_q.size() == 3) begin
      check("t5_w1", w_q[1], {32'(0), SRC_BASE + 32'(4)});
      check("t5_w2", w_q[2], {32'(4), SRC_BASE + 32'(5)});
    end
    check("t5_snap_n", 64'(gr_snap_q.size()), 64'(2));
    check("t5_snap1", 64'(gr_snap_q.size() > 1 ? gr_snap_q[1] : 4'h0), 64'(4'b1111));
    check("t5_m_cnt", 64'(m_q.size()), 64'(5));
    if (m_q.size() == 5) begin
      check("t5_m1", m_q[1], 64'({1'b1, FEAT_BASE + 32'(1)}));
      check("t5_m2", m_q[2], 64'({1'b0, FEAT_BASE}));
      check("t5_m4", m_q[4], 64'({1'b1, FEAT_BASE + 32'(2)}));
    end
    check("t5_done_cnt", 64'(done_cnt), 64'(1));
    check("t5_layer_back", 64'(gat_layer), 64'(0));

    // 6) reset in the middle of the weight load, then a fresh run
    set_cfg(1, 1, 6, 1, 0, 0, 0, 0);
    clear_mon();
    start_run();
    begin
      int k = 0;
      while (w_q.size() < 3 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("t6_reach_beat3", 64'(w_q.size()), 64'(3));
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", 64'(outs_vec()), 64'(0));
    check("t6_rst_bus", 64'(outs_bus_or()), 64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    set_cfg(1, 1, 6, 1, 0, 0, 0, 0);
    clear_mon();
    start_run();
    wait_done("t6");
    check("t6_h0", h_q.size() > 0 ? h_q[0] : '1, {32'(0), SRC_BASE});
    check("t6_w_cnt", 64'(w_q.size()), 64'(6));
    if (w_q.size() == 6) begin
      check("t6_w0", w_q[0], {32'(0), SRC_BASE + 32'(2)});
      check("t6_w5", w_q[5], {32'(20), SRC_BASE + 32'(7)});
    end
    check("t6_done_cnt", 64'(done_cnt), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
